// File: rtl/i2s_tx.sv
// I2S transmitter: audio-bus sink that serialises 24-bit L/R word pairs into 64-slot frames.
// Define I2S_TX_UNDERRUN_CNT_EN to add o_underrun_count, a saturating underrun counter.
// The din_valid/din_data/din_ready ports carry the audio_bus din modport signals.
module i2s_tx #(
  parameter int unsigned SCLK_DIV = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        din_valid,
  input  logic [23:0] din_data,
  output logic        din_ready,
  output logic        o_bclk,
  output logic        o_lrclk,
  output logic        o_sdata,
  output logic        o_underrun
`ifdef I2S_TX_UNDERRUN_CNT_EN
  ,
  output logic [15:0] o_underrun_count
`endif
);

  localparam int unsigned DivW = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
  localparam logic [DivW-1:0] DivLast = DivW'(SCLK_DIV - 1);

  logic [DivW-1:0] div_cnt_q, div_cnt_d;
  logic [5:0]      bit_cnt_q, bit_cnt_d;
  logic [63:0]     shreg_q, shreg_d;
  logic [23:0]     hold_l_q, hold_l_d, hold_r_q, hold_r_d;
  logic            hold_l_v_q, hold_l_v_d, hold_r_v_q, hold_r_v_d;
  logic            ch_q, ch_d, armed_q, armed_d;
  logic            bclk_q, bclk_d, lrclk_q, lrclk_d, sdata_q, sdata_d, underrun_q, underrun_d;

  logic        div_tc, bit_tick, frame_tick, pair_ready, accept;
  logic [63:0] frame;

  always_comb begin
    div_tc     = (div_cnt_q == DivLast);
    bit_tick   = div_tc && bclk_q;
    frame_tick = bit_tick && (bit_cnt_q == 6'd63);
    pair_ready = hold_l_v_q && hold_r_v_q;
    din_ready  = !rst && (ch_q ? !hold_r_v_q : !hold_l_v_q);
    accept     = din_valid && din_ready;
    frame      = '0;

    div_cnt_d  = div_tc ? '0 : div_cnt_q + 1'b1;
    bclk_d     = div_tc ? !bclk_q : bclk_q;
    bit_cnt_d  = bit_cnt_q;
    shreg_d    = shreg_q;
    hold_l_d   = hold_l_q;
    hold_r_d   = hold_r_q;
    hold_l_v_d = hold_l_v_q;
    hold_r_v_d = hold_r_v_q;
    ch_d       = ch_q;
    armed_d    = armed_q;
    lrclk_d    = lrclk_q;
    sdata_d    = sdata_q;
    underrun_d = 1'b0;

    if (accept) begin
      if (ch_q) begin
        hold_r_d   = din_data;
        hold_r_v_d = 1'b1;
      end else begin
        hold_l_d   = din_data;
        hold_l_v_d = 1'b1;
      end
      ch_d = !ch_q;
    end

    if (bit_tick) begin
      bit_cnt_d = bit_cnt_q + 6'd1;
      lrclk_d   = bit_cnt_d[5];
      if (frame_tick) begin
        // A half pair stays held; only a complete pair is consumed.
        if (pair_ready) begin
          frame      = {1'b0, hold_l_q, 8'b0, hold_r_q, 7'b0};
          hold_l_v_d = 1'b0;
          hold_r_v_d = 1'b0;
          armed_d    = 1'b1;
        end else begin
          underrun_d = armed_q;
        end
        sdata_d = frame[63];
        shreg_d = {frame[62:0], 1'b0};
      end else begin
        sdata_d = shreg_q[63];
        shreg_d = {shreg_q[62:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt_q  <= '0;
      bit_cnt_q  <= '0;
      shreg_q    <= '0;
      hold_l_q   <= '0;
      hold_r_q   <= '0;
      hold_l_v_q <= 1'b0;
      hold_r_v_q <= 1'b0;
      ch_q       <= 1'b0;
      armed_q    <= 1'b0;
      bclk_q     <= 1'b0;
      lrclk_q    <= 1'b0;
      sdata_q    <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      div_cnt_q  <= div_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shreg_q    <= shreg_d;
      hold_l_q   <= hold_l_d;
      hold_r_q   <= hold_r_d;
      hold_l_v_q <= hold_l_v_d;
      hold_r_v_q <= hold_r_v_d;
      ch_q       <= ch_d;
      armed_q    <= armed_d;
      bclk_q     <= bclk_d;
      lrclk_q    <= lrclk_d;
      sdata_q    <= sdata_d;
      underrun_q <= underrun_d;
    end
  end

  assign o_bclk     = bclk_q;
  assign o_lrclk    = lrclk_q;
  assign o_sdata    = sdata_q;
  assign o_underrun = underrun_q;

`ifdef I2S_TX_UNDERRUN_CNT_EN
  logic [15:0] ucnt_q;

  // Counts alongside the pulse so the count and o_underrun update on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      ucnt_q <= '0;
    end else if (underrun_d && (ucnt_q != 16'hFFFF)) begin
      ucnt_q <= ucnt_q + 16'd1;
    end
  end

  assign o_underrun_count = ucnt_q;
`endif

endmodule

// File: tb/tb_i2s_tx.sv
// Self-checking bench for i2s_tx: random/directed words, frame-level reference model,
// scoreboard queues of expected frames popped by a per-cycle monitor.
module tb_i2s_tx;

  localparam int unsigned D     = 2;
  localparam int          FRAME = 128 * D;

  logic        clk = 1'b0;
  logic        rst;
  logic        din_valid;
  logic [23:0] din_data;
  logic        din_ready;
  logic        bclk, lrclk, sdata, underrun;
`ifdef I2S_TX_UNDERRUN_CNT_EN
  logic [15:0] ucnt;
`endif

  i2s_tx #(.SCLK_DIV(D)) dut (
    .clk       (clk),
    .rst       (rst),
    .din_valid (din_valid),
    .din_data  (din_data),
    .din_ready (din_ready),
    .o_bclk    (bclk),
    .o_lrclk   (lrclk),
    .o_sdata   (sdata),
    .o_underrun(underrun)
`ifdef I2S_TX_UNDERRUN_CNT_EN
    ,
    .o_underrun_count(ucnt)
`endif
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int c      = 0;  // clk edges since reset release, as seen by the monitor

  // Reference model state
  logic [23:0] wq[$];        // accepted words not yet framed
  logic [63:0] frame_q[$];   // frames scheduled for the next boundary
  bit          und_q[$];
  logic [63:0] cur_frame;
  bit          cur_und;
  bit          armed;
  int          ucnt_model;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at t=%0t c=%0d: got %0h expected %0h", name, $time, c, act, exp);
    end
  endtask

  task automatic model_reset();
    wq.delete();
    frame_q.delete();
    und_q.delete();
    cur_frame  = '0;
    cur_und    = 1'b0;
    armed      = 1'b0;
    ucnt_model = 0;
  endtask

  // Monitor and scoreboard
  initial begin
    logic rst_last;
    int   slot;
    bit   exp_und, exp_ready;
    logic [23:0] l, r;
    rst_last = 1'b1;
    model_reset();
    forever begin
      @(negedge clk);
      if (rst_last) begin
        c = 0;
        model_reset();
      end else begin
        c++;
        if (c % FRAME == 0) begin
          if (frame_q.size() == 0) begin
            check("frame_q_empty", 64'(frame_q.size()), 64'd1);
            cur_frame = '0;
            cur_und   = 1'b0;
          end else begin
            cur_frame = frame_q.pop_front();
            cur_und   = und_q.pop_front();
          end
        end
      end
      slot    = (c / (2 * D)) % 64;
      exp_und = (c > 0 && c % FRAME == 0) ? cur_und : 1'b0;
      check("bclk", 64'(bclk), 64'((c / D) % 2));
      check("lrclk", 64'(lrclk), 64'(slot >= 32));
      check("sdata", 64'(sdata), 64'(cur_frame[63-slot]));
      check("underrun", 64'(underrun), 64'(exp_und));
`ifdef I2S_TX_UNDERRUN_CNT_EN
      if (exp_und && ucnt_model != 65535) ucnt_model++;
      check("underrun_count", 64'(ucnt), 64'(ucnt_model));
`endif
      exp_ready = !rst && (wq.size() < 2);
      check("ready", 64'(din_ready), 64'(exp_ready));
      if (!rst) begin
        if ((c + 1) % FRAME == 0) begin
          if (wq.size() >= 2) begin
            l = wq.pop_front();
            r = wq.pop_front();
            frame_q.push_back({1'b0, l, 8'b0, r, 7'b0});
            und_q.push_back(1'b0);
            armed = 1'b1;
          end else begin
            frame_q.push_back('0);
            und_q.push_back(armed);
          end
        end
        if (din_valid && exp_ready) wq.push_back(din_data);
      end
      rst_last = rst;
    end
  end

  task automatic send_word(input logic [23:0] w);
    int n;
    n         = 0;
    din_valid = 1'b1;
    din_data  = w;
    do begin
      @(negedge clk);
      n++;
    end while (!(din_ready && !rst) && n < 3000);
    checks++;
    if (n >= 3000) begin
      errors++;
      $display("FAIL send_timeout: word %0h not accepted within %0d cycles", w, n);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    din_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_phase(input int target);
    int n;
    n = 0;
    din_valid = 1'b0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (c % FRAME != target && n < 4 * FRAME);
    checks++;
    if (n >= 4 * FRAME) begin
      errors++;
      $display("FAIL wait_phase: phase %0d not reached in %0d cycles", target, n);
    end
  endtask

  initial begin
    rst       = 1'b1;
    din_valid = 1'b0;
    din_data  = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Basic pair during frame 0, then nothing: frame 2 is an underrun
    send_word(24'hABCDEF);
    send_word(24'h123456);
    idle(2 * FRAME + 20);

    // Backpressure: four words with valid held high
    send_word(24'h111111);
    send_word(24'h222222);
    send_word(24'h333333);
    send_word(24'h444444);
    idle(3 * FRAME);

    // Half pair across a boundary
    send_word(24'hA5A5A5);
    idle(FRAME + 10);
    send_word(24'h5A5A5A);
    idle(2 * FRAME);

    // Random words with random gaps
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 7) == 0) idle($urandom_range(FRAME / 2, FRAME + 40));
      else idle($urandom_range(0, 12));
      send_word(24'($urandom()));
    end
    idle(2 * FRAME);

    // Mid-frame reset with a pair held
    wait_phase(4);
    send_word(24'hFEDCBA);
    send_word(24'h0F0F0F);
    wait_phase(40 * 2 * D + 1);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    idle(3 * FRAME);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/i2s_tx.md
# i2s_tx

Audio-bus sink that serializes a stereo stream of 24-bit samples onto a standard I2S link (bit clock, word select, serial data). It sits at the output end of a `dfb` processing chain and consumes the chain's `audio_bus` directly. It provides the physical transmit path that complements the bus-level devices. Samples arrive on the bus as alternating left/right words and are framed as 64 bit clocks per stereo frame (32 per channel).

## Interface
- `SCLK_DIV`, default 4: `clk` cycles per bit-clock half-period; legal range ≥ 1. Bit period is 2·SCLK_DIV cycles, frame is 128·SCLK_DIV cycles.
- `clk` input 1: system clock; all logic is on the rising edge.
- `rst` input 1: reset, synchronous, active-high.
- `din` `audio_bus.din` modport: `valid`(in), `data[23:0]`(in), `ready`(out). The first word after reset is left; words then alternate left/right.
- `o_bclk` output 1: I2S bit clock.
- `o_lrclk` output 1: word select; 0 = left, 1 = right.
- `o_sdata` output 1: serial data, MSB first, one-bit I2S delay.
- `o_underrun` output 1: one-cycle pulse per underrun frame.

## Operation
- Divider: `div_cnt` counts 0..SCLK_DIV-1. At terminal count it wraps and toggles `o_bclk`. A toggle from 1→0 is a *bit tick*.
- `bit_cnt` (6 bits) increments on each bit tick and wraps from 63 to 0. Slot k spans from the tick that sets `bit_cnt=k` to the next tick.
- `o_lrclk` = 0 for slots 0..31 and 1 for slots 32..63. It is registered and changes on bit ticks.
- Frame word: F = {1'b0, L[23:0], 8'b0, R[23:0], 7'b0}. `o_sdata` in slot k = F[63−k].
  - L MSB is in slot 1 and L LSB in slot 24.
  - R MSB is in slot 33 and R LSB in slot 56.
  - All other slots are 0.
- Holding stage:
  - Two registers `hold_l` and `hold_r`, each with a valid flag.
  - Channel pointer `ch` selects the next word expected (0 = L).
  - `din.ready` = !rst && (ch==0 ? !hold_l_v : !hold_r_v).
  - On `valid && ready`: write the selected register, set its flag, flip `ch`.
- Frame load: on the bit tick where `bit_cnt` goes 63→0:
  - If both flags are set: load F from the hold registers into the 64-bit shift register, clear both flags, set `armed`.
  - Otherwise: load F = 0. If `armed`, pulse `o_underrun`. The partial pair (L only) is retained, and `ch` is unchanged.
- Before the first pair is loaded (`armed`=0), zero frames do not flag an underrun.
- Simultaneous accept and load cannot collide: `ready` is low while both flags are set. After a load clears the flags, `ready` returns high on the next cycle.
- Reset takes effect at any point, including mid-frame. It clears:
  - `div_cnt`, `bit_cnt`, the shift register, flags, `ch`, `armed`;
  - `o_bclk`, `o_lrclk`, `o_sdata`, `o_underrun`.
  - Held samples are discarded.

## Timing
- Reset values: `o_bclk`=0, `o_lrclk`=0, `o_sdata`=0, `o_underrun`=0, `din.ready`=0 while `rst`=1. `din.ready`=1 on the first cycle after release.
- After reset release, slot 0 of frame 0 begins immediately. Frame 0 is always zero.
  - First rising `o_bclk` occurs SCLK_DIV cycles after release.
  - First bit tick occurs 2·SCLK_DIV cycles after release.
- All outputs are registered. `o_sdata` and `o_lrclk` change in the same `clk` edge as `o_bclk` falls, and are stable across the rising edge.
- Latency: a pair completed before a 63→0 tick appears in the next frame. L MSB drives `o_sdata` one bit period (2·SCLK_DIV cycles) after that tick.
- Throughput: at most 2 words are buffered. Upstream stalls until the next frame boundary.
- `o_underrun` is high for exactly the one `clk` cycle of the 63→0 tick.

## Configuration
- `I2S_TX_UNDERRUN_CNT_EN` defined:
  - Adds output `o_underrun_count` [15:0].
  - The counter increments on each `o_underrun` pulse and saturates at 16'hFFFF.
  - It is cleared by `rst`.
- Macro undefined: the port and counter are absent. All other behaviour is identical.

## Test plan
- Reset: hold `rst` 3 cycles, SCLK_DIV=2.
  - During reset: all outputs 0, `ready`=0.
  - Cycle after release: `ready`=1.
  - `o_bclk` rises at cycle 2 and falls at cycle 4 after release.
- Basic frame: send L=24'hABCDEF, R=24'h123456 during frame 0.
  - Frame 1 shows `o_sdata` slots 1..24 = ABCDEF MSB-first and slots 33..56 = 123456. All other slots are 0.
  - `o_lrclk` is low for slots 0..31.
- Backpressure: hold `valid`=1 with 4 words.
  - Two words are accepted, then `ready`=0 until the cycle after the 63→0 tick.
  - Words 3/4 then appear in the frame after next.
- Underrun: send one pair only.
  - The following frame is all zeros, with one `o_underrun` pulse.
  - With the macro, `o_underrun_count`=1.
- Half pair: send L only after arming.
  - The boundary frame is zero and `o_underrun` pulses.
  - `ready` stays 1, expecting R.
  - After R arrives, L/R go out together in the next frame.
- Mid-frame reset: pulse `rst` for 1 cycle during slot 40 with a pair held.
  - Outputs go to 0, the hold is discarded, and the next frame is zero with no underrun.
